// File: rtl/ad9648_emu_if.sv
// ----------------------------------------------------------------------------
// ad9648_emu_if
//   Bundles the control, LUT-load and sample-output signals of the AD9648
//   output-interface emulator so they travel as one port.
//
//   modport master : controller side; drives the run/configuration/LUT
//                    signals and observes the emulated ADC outputs.
//   modport slave  : emulator side (ad9648_emu).
//
//   Signals (names keep the emulator's point of view):
//     enable_in      run request (high = run)
//     mode_in        0 fixed, 1 ramp, 2 LUT, 3 reserved (fixed)
//     step_in        ramp increment / LUT phase increment
//     b_offset_in    channel B value offset (ramp) or phase offset (LUT)
//     fixed_in       fixed-mode value for A; B = ~fixed_in
//     or_hi_in       overrange upper threshold (offset binary)
//     or_lo_in       overrange lower threshold (offset binary)
//     twos_comp_in   1 = two's complement output (MSB inverted)
//     mux_in         1 = A/B multiplexed onto data_a_out
//     lut_we_in      LUT write strobe
//     lut_addr_in    LUT write address
//     lut_data_in    LUT write data (offset binary)
//     data_a_out     channel A sample or multiplexed stream
//     data_b_out     channel B sample
//     overrange_a_out/overrange_b_out  flags aligned with their data
//     chan_b_out     in mux mode, data_a_out carries channel B
//     valid_out      outputs carry valid samples
// ----------------------------------------------------------------------------
interface ad9648_emu_if #(
  parameter int bit_width = 14,
  parameter int lut_aw    = 8
);
  logic                 enable_in;
  logic [1:0]           mode_in;
  logic [bit_width-1:0] step_in;
  logic [bit_width-1:0] b_offset_in;
  logic [bit_width-1:0] fixed_in;
  logic [bit_width-1:0] or_hi_in;
  logic [bit_width-1:0] or_lo_in;
  logic                 twos_comp_in;
  logic                 mux_in;
  logic                 lut_we_in;
  logic [lut_aw-1:0]    lut_addr_in;
  logic [bit_width-1:0] lut_data_in;

  logic [bit_width-1:0] data_a_out;
  logic [bit_width-1:0] data_b_out;
  logic                 overrange_a_out;
  logic                 overrange_b_out;
  logic                 chan_b_out;
  logic                 valid_out;

  modport master (
    output enable_in, mode_in, step_in, b_offset_in, fixed_in,
           or_hi_in, or_lo_in, twos_comp_in, mux_in,
           lut_we_in, lut_addr_in, lut_data_in,
    input  data_a_out, data_b_out, overrange_a_out, overrange_b_out,
           chan_b_out, valid_out
  );

  modport slave (
    input  enable_in, mode_in, step_in, b_offset_in, fixed_in,
           or_hi_in, or_lo_in, twos_comp_in, mux_in,
           lut_we_in, lut_addr_in, lut_data_in,
    output data_a_out, data_b_out, overrange_a_out, overrange_b_out,
           chan_b_out, valid_out
  );
endinterface

// File: rtl/ad9648_emu.sv
// ----------------------------------------------------------------------------
// ad9648_emu
//   Transmit-side emulator of the AD9648 dual 14-bit ADC output interface.
//   Produces two sample streams (fixed, ramp or LUT waveform) with overrange
//   flags, an ADC-like start-up latency and an optional A/B multiplexed mode.
//
//   Ports:
//     clk_in    sample clock, rising edge
//     rst_n_in  asynchronous active-low reset
//     bus       ad9648_emu_if.slave (configuration, LUT load, sample outputs)
//
//   Parameters:
//     bit_width  sample width
//     lut_aw     LUT address width (depth 2**lut_aw)
//     pipe_lat   cycles from enable to first valid sample, 1..15
// ----------------------------------------------------------------------------
module ad9648_emu #(
  parameter int bit_width = 14,
  parameter int lut_aw    = 8,
  parameter int pipe_lat  = 10
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  ad9648_emu_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int          lut_depth = 1 << lut_aw;
  localparam logic [3:0]  last_cnt  = 4'(pipe_lat - 1);

  state_t               state;
  logic [3:0]           lat_cnt;
  logic [bit_width-1:0] n;          // sample index
  logic                 slot;       // mux phase: 0 = A, 1 = B

  logic [bit_width-1:0] data_a_q, data_b_q;
  logic                 ovr_a_q, ovr_b_q, chan_b_q, valid_q;

  // --------------------------------------------------------------------------
  // Waveform LUT: one synchronous write port, two combinational read ports
  // feeding the output registers. A read in the same cycle as a write to the
  // same address captures the old word; the new word is seen a cycle later.
  // --------------------------------------------------------------------------
  logic [bit_width-1:0] lut [lut_depth];

  // NOTE: memories get no reset branch; clearing every word would force the
  // array into flops and the contents are defined by the loader anyway.
  always_ff @(posedge clk_in) begin
    if (bus.lut_we_in) lut[bus.lut_addr_in] <= bus.lut_data_in;
  end

  // --------------------------------------------------------------------------
  // Sample generation for the current index n (offset binary)
  // --------------------------------------------------------------------------
  logic [bit_width-1:0] phase_a, phase_b;
  logic [bit_width-1:0] raw_a, raw_b;
  logic                 ovr_a, ovr_b;
  logic [bit_width-1:0] fmt_mask;
  logic                 present;
  logic [bit_width-1:0] nxt_data_a, nxt_data_b;
  logic                 nxt_ovr_a, nxt_ovr_b, nxt_chan_b;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    phase_a    = n * bus.step_in;
    phase_b    = phase_a + bus.b_offset_in;
    raw_a      = bus.fixed_in;
    raw_b      = ~bus.fixed_in;
    nxt_data_a = '0;
    nxt_data_b = '0;
    nxt_ovr_a  = 1'b0;
    nxt_ovr_b  = 1'b0;
    nxt_chan_b = 1'b0;

    case (bus.mode_in)
      2'd1: begin
        raw_a = phase_a;
        raw_b = phase_b;
      end
      2'd2: begin
        raw_a = lut[phase_a[lut_aw-1:0]];
        raw_b = lut[phase_b[lut_aw-1:0]];
      end
      default: ;  // fixed and reserved keep the fixed-value defaults
    endcase

    // Flags come from the offset-binary value, before format conversion.
    ovr_a    = (raw_a >= bus.or_hi_in) || (raw_a <= bus.or_lo_in);
    ovr_b    = (raw_b >= bus.or_hi_in) || (raw_b <= bus.or_lo_in);
    fmt_mask = {bus.twos_comp_in, {(bit_width-1){1'b0}}};

    // A sample is presented on the last FILL edge and on every RUN edge.
    present = bus.enable_in &&
              ((state == RUN) || ((state == FILL) && (lat_cnt == last_cnt)));

    if (bus.mux_in) begin
      if (!slot) begin
        nxt_data_a = raw_a ^ fmt_mask;
        nxt_ovr_a  = ovr_a;
      end else begin
        nxt_data_a = raw_b ^ fmt_mask;
        nxt_ovr_a  = ovr_b;
        nxt_chan_b = 1'b1;
      end
    end else begin
      nxt_data_a = raw_a ^ fmt_mask;
      nxt_data_b = raw_b ^ fmt_mask;
      nxt_ovr_a  = ovr_a;
      nxt_ovr_b  = ovr_b;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM, sample index and registered outputs
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      n        <= '0;
      slot     <= 1'b0;
      data_a_q <= '0;
      data_b_q <= '0;
      ovr_a_q  <= 1'b0;
      ovr_b_q  <= 1'b0;
      chan_b_q <= 1'b0;
      valid_q  <= 1'b0;
    end else if (!bus.enable_in) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      n        <= '0;
      slot     <= 1'b0;
      data_a_q <= '0;
      data_b_q <= '0;
      ovr_a_q  <= 1'b0;
      ovr_b_q  <= 1'b0;
      chan_b_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state   <= FILL;
          lat_cnt <= '0;
        end
        FILL: begin
          if (lat_cnt == last_cnt) state <= RUN;
          else                     lat_cnt <= lat_cnt + 4'd1;
        end
        RUN:     ;
        default: state <= IDLE;
      endcase

      if (present) begin
        data_a_q <= nxt_data_a;
        data_b_q <= nxt_data_b;
        ovr_a_q  <= nxt_ovr_a;
        ovr_b_q  <= nxt_ovr_b;
        chan_b_q <= nxt_chan_b;
        valid_q  <= 1'b1;
        // Mux mode spends two slots per index; leaving mux mode parks the
        // phase at slot 0 so re-entering always starts with channel A.
        if (bus.mux_in && !slot) begin
          slot <= 1'b1;
        end else begin
          slot <= 1'b0;
          n    <= n + 1'b1;
        end
      end else begin
        data_a_q <= '0;
        data_b_q <= '0;
        ovr_a_q  <= 1'b0;
        ovr_b_q  <= 1'b0;
        chan_b_q <= 1'b0;
        valid_q  <= 1'b0;
      end
    end
  end

  assign bus.data_a_out      = data_a_q;
  assign bus.data_b_out      = data_b_q;
  assign bus.overrange_a_out = ovr_a_q;
  assign bus.overrange_b_out = ovr_b_q;
  assign bus.chan_b_out      = chan_b_q;
  assign bus.valid_out       = valid_q;

endmodule

// File: tb/tb_ad9648_emu.sv
// ----------------------------------------------------------------------------
// tb_ad9648_emu
//   Directed bench for ad9648_emu: start-up latency, ramp wrap and overrange,
//   LUT playback with phase offset, mux/two's-complement output, enable drop,
//   asynchronous reset and LUT read/write collision.
// ----------------------------------------------------------------------------
module tb_ad9648_emu;
  localparam int bw = 14;
  localparam int aw = 8;
  localparam int pl = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ad9648_emu_if #(.bit_width(bw), .lut_aw(aw)) bus ();

  ad9648_emu #(.bit_width(bw), .lut_aw(aw), .pipe_lat(pl)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Advance one rising edge, then settle on the falling edge for sampling.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drop enable for one edge, re-raise it and wait out the start-up latency;
  // on return the outputs show sample n = 0 (slot 0 in mux mode).
  task automatic restart();
    bus.enable_in = 1'b0;
    tick();
    bus.enable_in = 1'b1;
    repeat (pl + 1) tick();
  endtask

  task automatic set_cfg(input logic [1:0] mode, input logic [bw-1:0] step,
                         input logic [bw-1:0] boff, input logic [bw-1:0] hi,
                         input logic [bw-1:0] lo, input logic twos,
                         input logic mux);
    bus.mode_in      = mode;
    bus.step_in      = step;
    bus.b_offset_in  = boff;
    bus.or_hi_in     = hi;
    bus.or_lo_in     = lo;
    bus.twos_comp_in = twos;
    bus.mux_in       = mux;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", bus.valid_out); end
    n_cmp++; if (bus.data_a_out !== '0) begin n_bad++; $display("FAIL reset_data_a got %h want 0", bus.data_a_out); end
    n_cmp++; if (bus.data_b_out !== '0) begin n_bad++; $display("FAIL reset_data_b got %h want 0", bus.data_b_out); end
    n_cmp++; if ({bus.overrange_a_out, bus.overrange_b_out, bus.chan_b_out} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags got %b want 000", {bus.overrange_a_out, bus.overrange_b_out, bus.chan_b_out});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL idle_valid got %b want 0", bus.valid_out); end
  endtask

  task automatic test_ramp_startup();
    set_cfg(2'd1, 14'd1, 14'd100, 14'h3FFF, 14'd0, 1'b0, 1'b0);
    bus.enable_in = 1'b1;
    for (int j = 0; j < pl; j++) begin
      tick();
      n_cmp++; if (bus.valid_out !== 1'b0 || bus.data_a_out !== '0 || bus.data_b_out !== '0) begin
        n_bad++; $display("FAIL fill_quiet edge=%0d got v=%b a=%h b=%h want 0", j, bus.valid_out, bus.data_a_out, bus.data_b_out);
      end
    end
    for (int s = 0; s < 6; s++) begin
      tick();
      n_cmp++; if (bus.valid_out !== 1'b1) begin n_bad++; $display("FAIL ramp_valid s=%0d got %b want 1", s, bus.valid_out); end
      n_cmp++; if (bus.data_a_out !== 14'(s)) begin n_bad++; $display("FAIL ramp_a s=%0d got %0d want %0d", s, bus.data_a_out, s); end
      n_cmp++; if (bus.data_b_out !== 14'(s + 100)) begin n_bad++; $display("FAIL ramp_b s=%0d got %0d want %0d", s, bus.data_b_out, s + 100); end
      n_cmp++; if (bus.overrange_a_out !== (s == 0)) begin n_bad++; $display("FAIL ramp_ovr_a s=%0d got %b want %b", s, bus.overrange_a_out, s == 0); end
    end
  endtask

  task automatic test_wrap_overrange();
    logic [bw-1:0] exp_a [6] = '{14'd0, 14'd4096, 14'd8192, 14'd12288, 14'd0, 14'd4096};
    logic          exp_o [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    set_cfg(2'd1, 14'd4096, 14'd0, 14'd12288, 14'd0, 1'b0, 1'b0);
    restart();
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (bus.data_a_out !== exp_a[i]) begin n_bad++; $display("FAIL wrap_a i=%0d got %0d want %0d", i, bus.data_a_out, exp_a[i]); end
      n_cmp++; if (bus.overrange_a_out !== exp_o[i]) begin n_bad++; $display("FAIL wrap_ovr_a i=%0d got %b want %b", i, bus.overrange_a_out, exp_o[i]); end
      n_cmp++; if (bus.overrange_b_out !== exp_o[i]) begin n_bad++; $display("FAIL wrap_ovr_b i=%0d got %b want %b", i, bus.overrange_b_out, exp_o[i]); end
      tick();
    end
  endtask

  task automatic test_lut();
    bus.enable_in = 1'b0;
    for (int i = 0; i < 256; i++) begin
      bus.lut_we_in   = 1'b1;
      bus.lut_addr_in = 8'(i);
      bus.lut_data_in = 14'(i * 64);
      tick();
    end
    bus.lut_we_in = 1'b0;
    set_cfg(2'd2, 14'd1, 14'd64, 14'h3FFF, 14'd0, 1'b0, 1'b0);
    restart();
    for (int n = 0; n < 260; n++) begin
      n_cmp++; if (bus.data_a_out !== 14'((n % 256) * 64)) begin
        n_bad++; $display("FAIL lut_a n=%0d got %0d want %0d", n, bus.data_a_out, (n % 256) * 64);
      end
      n_cmp++; if (bus.data_b_out !== 14'(((n + 64) % 256) * 64)) begin
        n_bad++; $display("FAIL lut_b n=%0d got %0d want %0d", n, bus.data_b_out, ((n + 64) % 256) * 64);
      end
      tick();
    end
  endtask

  task automatic test_lut_collision();
    set_cfg(2'd2, 14'd1, 14'd64, 14'h3FFF, 14'd0, 1'b0, 1'b0);
    restart();
    repeat (4) tick();                    // showing n = 4
    bus.lut_we_in   = 1'b1;
    bus.lut_addr_in = 8'd5;
    bus.lut_data_in = 14'h1234;
    tick();                               // n = 5 read while address 5 written
    bus.lut_we_in = 1'b0;
    n_cmp++; if (bus.data_a_out !== 14'd320) begin n_bad++; $display("FAIL coll_old got %h want %h", bus.data_a_out, 14'd320); end
    tick();
    n_cmp++; if (bus.data_a_out !== 14'd384) begin n_bad++; $display("FAIL coll_next got %h want %h", bus.data_a_out, 14'd384); end
    repeat (191) tick();                  // n = 197, B reads address 5
    n_cmp++; if (bus.data_b_out !== 14'h1234) begin n_bad++; $display("FAIL coll_new_b got %h want 1234", bus.data_b_out); end
    repeat (64) tick();                   // n = 261, A reads address 5
    n_cmp++; if (bus.data_a_out !== 14'h1234) begin n_bad++; $display("FAIL coll_new_a got %h want 1234", bus.data_a_out); end
    bus.enable_in   = 1'b0;
    bus.lut_we_in   = 1'b1;
    bus.lut_data_in = 14'd320;
    tick();
    bus.lut_we_in = 1'b0;
  endtask

  task automatic test_mux_twos();
    logic [bw-1:0] ramp_a [6] = '{14'd0, 14'd100, 14'd1, 14'd101, 14'd2, 14'd102};
    bus.fixed_in = 14'h2000;
    set_cfg(2'd0, 14'd0, 14'd0, 14'h3FFF, 14'h1FFF, 1'b1, 1'b1);
    restart();
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (bus.data_a_out !== ((k % 2) ? 14'h3FFF : 14'h0000)) begin
        n_bad++; $display("FAIL mux_a k=%0d got %h want %h", k, bus.data_a_out, (k % 2) ? 14'h3FFF : 14'h0000);
      end
      n_cmp++; if (bus.chan_b_out !== 1'(k % 2)) begin n_bad++; $display("FAIL mux_chan k=%0d got %b want %0d", k, bus.chan_b_out, k % 2); end
      n_cmp++; if (bus.overrange_a_out !== 1'(k % 2)) begin n_bad++; $display("FAIL mux_ovr k=%0d got %b want %0d", k, bus.overrange_a_out, k % 2); end
      n_cmp++; if (bus.data_b_out !== '0 || bus.overrange_b_out !== 1'b0) begin
        n_bad++; $display("FAIL mux_b_quiet k=%0d got %h/%b want 0/0", k, bus.data_b_out, bus.overrange_b_out);
      end
      tick();
    end
    set_cfg(2'd1, 14'd1, 14'd100, 14'h3FFF, 14'd0, 1'b0, 1'b1);
    restart();
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (bus.data_a_out !== ramp_a[k]) begin n_bad++; $display("FAIL mux_ramp k=%0d got %0d want %0d", k, bus.data_a_out, ramp_a[k]); end
      tick();
    end
    bus.mux_in = 1'b0;                    // showing slot 0 of n = 3
    tick();
    n_cmp++; if (bus.chan_b_out !== 1'b0 || bus.data_b_out !== 14'd103) begin
      n_bad++; $display("FAIL mux_exit got chan=%b b=%0d want 0/103", bus.chan_b_out, bus.data_b_out);
    end
  endtask

  task automatic test_enable_drop_reset();
    set_cfg(2'd1, 14'd1, 14'd100, 14'h3FFF, 14'd0, 1'b0, 1'b0);
    restart();
    repeat (3) tick();
    n_cmp++; if (bus.data_a_out !== 14'd3) begin n_bad++; $display("FAIL drop_pre got %0d want 3", bus.data_a_out); end
    bus.enable_in = 1'b0;
    tick();
    n_cmp++; if (bus.valid_out !== 1'b0 || bus.data_a_out !== '0 || bus.data_b_out !== '0) begin
      n_bad++; $display("FAIL drop_off got v=%b a=%h b=%h want 0", bus.valid_out, bus.data_a_out, bus.data_b_out);
    end
    bus.enable_in = 1'b1;
    repeat (pl) tick();
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL drop_relat got %b want 0", bus.valid_out); end
    tick();
    n_cmp++; if (bus.valid_out !== 1'b1 || bus.data_a_out !== 14'd0 || bus.data_b_out !== 14'd100) begin
      n_bad++; $display("FAIL drop_restart got v=%b a=%0d b=%0d want 1/0/100", bus.valid_out, bus.data_a_out, bus.data_b_out);
    end
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.valid_out !== 1'b0 || bus.data_a_out !== '0 || bus.data_b_out !== '0) begin
      n_bad++; $display("FAIL async_rst got v=%b a=%h b=%h want 0", bus.valid_out, bus.data_a_out, bus.data_b_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (pl) tick();
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL rst_relat got %b want 0", bus.valid_out); end
    tick();
    n_cmp++; if (bus.valid_out !== 1'b1 || bus.data_a_out !== 14'd0) begin
      n_bad++; $display("FAIL rst_restart got v=%b a=%0d want 1/0", bus.valid_out, bus.data_a_out);
    end
  endtask

  initial begin
    bus.enable_in    = 1'b0;
    bus.fixed_in     = '0;
    bus.lut_we_in    = 1'b0;
    bus.lut_addr_in  = '0;
    bus.lut_data_in  = '0;
    set_cfg(2'd0, 14'd0, 14'd0, 14'h3FFF, 14'd0, 1'b0, 1'b0);
    test_reset();
    test_ramp_startup();
    test_wrap_overrange();
    test_lut();
    test_lut_collision();
    test_mux_twos();
    test_enable_drop_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
